hg_turn_sequencer: RTL and testbench
====================================

HG_TURN_SEQUENCER -- requirements
Module: hg_turn_sequencer

Interface
REQ-001 SHALL take parameter MSB, default 13, as the index of the elapsed/startTime MSB.
REQ-002 SHALL take parameter DEPTH, default 8, as the number of turn-step table entries.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cfg_valid, input, 1, a turn-step write request.
REQ-006 SHALL have port cfg_ready, output, 1, the table can accept a step.
REQ-007 SHALL have port cfg_turn, input, 2, the step: bit0 turns small, bit1 turns large.
REQ-008 SHALL have port cfg_clear, input, 1, empties the table.
REQ-009 SHALL have port target, input, MSB+1, the interval to measure.
REQ-010 SHALL have port go, input, 1, starts a run.
REQ-011 SHALL have ports hg_done and hg_failed, input, 1 each, the done/failed flags from the hourglass model.
REQ-012 SHALL have ports turnSmall and turnLarge, output, 1 each, turn commands to the hourglass model.
REQ-013 SHALL have port startTime, output, MSB+1, the interval presented to the hourglass model.
REQ-014 SHALL have port busy, output, 1, high in RUN and REPORT.
REQ-015 SHALL have port result, output, 2, the run outcome: 00 none, 01 done, 10 failed, 11 exhausted.
REQ-016 SHALL have port result_valid, output, 1, a one-cycle outcome strobe.
REQ-017 SHALL have port count, output, 4, the number of steps loaded.

Function
REQ-018 SHALL implement states IDLE, RUN and REPORT.
REQ-019 IDLE: cfg_ready SHALL be combinational, equal to (state==IDLE && count<DEPTH && !go && !cfg_clear).
REQ-020 A write SHALL occur on cfg_valid&&cfg_ready: table[count]<=cfg_turn and count<=count+1.
REQ-021 When count==DEPTH, cfg_ready SHALL be 0, further writes SHALL be dropped and count SHALL NOT wrap.
REQ-022 cfg_clear in IDLE SHALL set count to 0; table contents are don't-care; cfg_clear outside IDLE SHALL be ignored.
REQ-023 go in IDLE with count>0 SHALL latch startTime<=target, set ptr<=0, and enter RUN next cycle; go with count==0 SHALL be ignored.
REQ-024 Priority in IDLE SHALL be go > cfg_clear > write.
REQ-025 RUN: turnSmall/turnLarge SHALL be registered copies of table[ptr] bits 0/1, presented one step per cycle starting the first RUN cycle; ptr increments each RUN cycle.
REQ-026 RUN exit SHALL be evaluated each cycle, in priority order: hg_failed -> result 10; else hg_done -> 01; else step ptr==count-1 just issued -> 11.
REQ-027 On exit the block SHALL enter REPORT for exactly one cycle, with result_valid=1 and result held until the next go.
REQ-028 turnSmall/turnLarge SHALL be 0 in IDLE and REPORT; go, cfg_valid and cfg_clear SHALL be ignored in RUN and REPORT.
REQ-029 startTime SHALL remain stable from go until the next accepted go.
REQ-030 The table contents SHALL persist across runs until cfg_clear.

Reset
REQ-031 Asserting reset at any time, including mid-RUN, SHALL immediately set state IDLE, count 0, ptr 0, startTime 0, result 00, and turnSmall, turnLarge, result_valid and busy to 0.
REQ-032 A run interrupted by reset SHALL produce no result_valid strobe.

Structure
REQ-033 Package hg_pkg SHALL hold the state encoding, the result codes (RES_NONE, RES_DONE, RES_FAIL, RES_EXH), the SMALL=4 and LARGE=7 constants, and the MSB default.
REQ-034 The step storage SHALL be sub-module hg_turn_table, a DEPTH x 2 register file with write port and asynchronous read; the FSM stays in the top module.

Verification
REQ-035 Load steps 01,10,11; count==3; go with target=11; hg flags held 0 -> turns (S,L)=(1,0),(0,1),(1,1) on cycles 1-3, then result=11 with one result_valid pulse and busy low after.
REQ-036 Load 8 steps, then assert cfg_valid for 2 more cycles -> cfg_ready=0, count stays 8, no write occurs.
REQ-037 Run with 4 steps; raise hg_done and hg_failed together in RUN cycle 2 -> result=10, turns 0 from the REPORT cycle onward.
REQ-038 go with count==0 -> remains IDLE, busy=0, startTime unchanged; go and cfg_valid in the same IDLE cycle -> RUN entered, count unchanged.
REQ-039 Assert reset in RUN cycle 2 of 5 -> outputs zero immediately, no result_valid, count==0 afterwards.
REQ-040 Connect to the hourglass model with target=4 and steps {01, 00} -> hg_done observed; result=01.

Source files
------------

// File: rtl/hg_pkg.sv
// hg_pkg: shared state encoding, result codes and hourglass constants
package hg_pkg;
    localparam int MSB_DEFAULT = 13;
    localparam int SMALL = 4;
    localparam int LARGE = 7;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_DONE = 2'b01;
    localparam logic [1:0] RES_FAIL = 2'b10;
    localparam logic [1:0] RES_EXH = 2'b11;
    // Outcome of a finished run; failure outranks done, exhaustion is the fallback
    function automatic logic [1:0] exit_code(input logic failed, input logic done);
        return failed ? RES_FAIL : done ? RES_DONE : RES_EXH;
    endfunction
endpackage

// File: rtl/hg_turn_table.sv
// hg_turn_table: DEPTH x 2 turn-step register file, one write port, async read
module hg_turn_table #(
    parameter int DEPTH = 8,
    parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);
    logic [1:0] mem [DEPTH];
    // Contents are don't-care after a clear, so the storage carries no reset
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/hg_turn_sequencer.sv
// hg_turn_sequencer: plays a loaded list of hourglass turn steps and reports the outcome
module hg_turn_sequencer
    import hg_pkg::*;
#(
    parameter int MSB = MSB_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [1:0]   cfg_turn,
    input  logic         cfg_clear,
    input  logic [MSB:0] target,
    input  logic         go,
    input  logic         hg_done,
    input  logic         hg_failed,
    output logic         turnSmall,
    output logic         turnLarge,
    output logic [MSB:0] startTime,
    output logic         busy,
    output logic [1:0]   result,
    output logic         result_valid,
    output logic [3:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    logic [1:0] state;
    logic [3:0] ptr;
    logic [1:0] rd_turn;
    logic [AW-1:0] rd_addr;
    logic idle, wr, start, last, stop;
    assign idle = state == ST_IDLE;
    assign cfg_ready = idle && count < DEPTH_C && !go && !cfg_clear;
    assign wr = cfg_valid && cfg_ready;
    assign start = idle && go && count != 4'd0;
    assign last = ptr == count - 4'd1;
    assign stop = hg_failed || hg_done || last;
    // While idle, prefetch step 0 so it is on the turn outputs in the first RUN cycle
    assign rd_addr = (state == ST_RUN) ? AW'(ptr + 4'd1) : '0;
    assign busy = !idle;
    assign result_valid = state == ST_REPORT;
    hg_turn_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
        .clock(clock),
        .we(wr),
        .waddr(AW'(count)),
        .wdata(cfg_turn),
        .raddr(rd_addr),
        .rdata(rd_turn)
    );
    // Sequencer FSM: load/clear in IDLE, one step per RUN cycle, single REPORT cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= 4'd0;
            ptr <= 4'd0;
            startTime <= '0;
            result <= RES_NONE;
            {turnLarge, turnSmall} <= 2'b00;
        end else if (start) begin
            state <= ST_RUN;
            startTime <= target;
            ptr <= 4'd0;
            result <= RES_NONE;
            {turnLarge, turnSmall} <= rd_turn;
        end else if (idle && cfg_clear) begin
            count <= 4'd0;
        end else if (wr) begin
            count <= count + 4'd1;
        end else if (state == ST_RUN) begin
            state <= stop ? ST_REPORT : ST_RUN;
            result <= stop ? exit_code(hg_failed, hg_done) : result;
            ptr <= stop ? ptr : ptr + 4'd1;
            {turnLarge, turnSmall} <= stop ? 2'b00 : rd_turn;
        end else if (state == ST_REPORT) begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_hg_turn_sequencer.sv
// tb_hg_turn_sequencer: randomized scenario bench against a step-list reference model
module tb_hg_turn_sequencer;
    import hg_pkg::*;
    localparam int MSB = 13;
    localparam int DEPTH = 8;
    logic clock = 0, reset = 0, cfg_valid = 0, cfg_clear = 0, go = 0;
    logic t_done = 0, t_failed = 0, use_model = 0;
    logic [1:0] cfg_turn = 0;
    logic [MSB:0] target = 0;
    logic cfg_ready, turnSmall, turnLarge, busy, result_valid, hg_done, hg_failed;
    logic [MSB:0] startTime;
    logic [1:0] result;
    logic [3:0] count;
    int m_acc = 0;
    int n_vec = 0, n_err = 0;
    logic [1:0] tbl[$];
    logic [MSB:0] exp_start = 0;

    hg_turn_sequencer #(.MSB(MSB), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_turn(cfg_turn), .cfg_clear(cfg_clear), .target(target), .go(go),
        .hg_done(hg_done), .hg_failed(hg_failed), .turnSmall(turnSmall), .turnLarge(turnLarge),
        .startTime(startTime), .busy(busy), .result(result), .result_valid(result_valid),
        .count(count)
    );

    always #5 clock = ~clock;

    // Hourglass model: each turn adds that glass's full duration to the measured time
    always @(posedge clock) m_acc <= !busy ? 0 : m_acc + (turnSmall ? SMALL : 0) + (turnLarge ? LARGE : 0);
    assign hg_done = use_model ? (busy && m_acc == int'(startTime)) : t_done;
    assign hg_failed = use_model ? (busy && m_acc > int'(startTime)) : t_failed;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [1:0] t);
        cfg_valid = 1;
        cfg_turn = t;
        tick();
        cfg_valid = 0;
        if (tbl.size() < DEPTH) tbl.push_back(t);
    endtask

    task automatic clear_tbl;
        cfg_clear = 1;
        tick();
        cfg_clear = 0;
        tbl.delete();
    endtask

    task automatic run_check(input string nm, input logic [MSB:0] tg, input int fail_c, input int done_c, input bit junk);
        int n, len;
        logic [1:0] exp_res;
        n = tbl.size();
        len = n;
        exp_res = RES_EXH;
        for (int c = 1; c <= n; c++)
            if (c == fail_c || c == done_c) begin
                len = c;
                exp_res = (c == fail_c) ? RES_FAIL : RES_DONE;
                break;
            end
        go = 1;
        target = tg;
        tick();
        go = 0;
        exp_start = tg;
        target = MSB'($urandom);
        for (int c = 1; c <= len; c++) begin
            n_vec++;
            if ({turnLarge, turnSmall} !== tbl[c-1] || busy !== 1'b1 || result_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s run cycle %0d: turns=%b busy=%b rv=%b, expected turns=%b busy=1 rv=0",
                         nm, c, {turnLarge, turnSmall}, busy, result_valid, tbl[c-1]);
            end
            t_failed = (c == fail_c);
            t_done = (c == done_c);
            if (junk) begin
                go = 1'($urandom);
                cfg_valid = 1'($urandom);
                cfg_clear = 1'($urandom);
                cfg_turn = 2'($urandom);
            end
            tick();
        end
        t_failed = 0;
        t_done = 0;
        n_vec++;
        if (result_valid !== 1'b1 || result !== exp_res || {turnLarge, turnSmall} !== 2'b00 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s report: rv=%b result=%b turns=%b busy=%b, expected rv=1 result=%b turns=00 busy=1",
                     nm, result_valid, result, {turnLarge, turnSmall}, busy, exp_res);
        end
        tick();
        go = 0;
        cfg_valid = 0;
        cfg_clear = 0;
        n_vec++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp_res || startTime !== exp_start || count !== 4'(n)) begin
            n_err++;
            $display("FAIL %s after: rv=%b busy=%b result=%b start=%0d count=%0d, expected rv=0 busy=0 result=%b start=%0d count=%0d",
                     nm, result_valid, busy, result, startTime, count, exp_res, exp_start, n);
        end
    endtask

    task automatic test_reset;
        reset = 1;
        #2;
        n_vec++;
        if (busy !== 0 || turnSmall !== 0 || turnLarge !== 0 || result_valid !== 0 || result !== RES_NONE || count !== 0 || startTime !== 0) begin
            n_err++;
            $display("FAIL reset: busy=%b ts=%b tl=%b rv=%b result=%b count=%0d start=%0d, expected all zero",
                     busy, turnSmall, turnLarge, result_valid, result, count, startTime);
        end
        @(negedge clock);
        reset = 0;
        tick();
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: cfg_ready=%b, expected 1", cfg_ready);
        end
    endtask

    task automatic test_basic;
        clear_tbl();
        load(2'b01);
        load(2'b10);
        load(2'b11);
        n_vec++;
        if (count !== 4'd3) begin
            n_err++;
            $display("FAIL basic_count: count=%0d, expected 3", count);
        end
        run_check("basic", 14'd11, 0, 0, 0);
    endtask

    task automatic test_full;
        clear_tbl();
        for (int i = 0; i < DEPTH; i++) load(2'($urandom));
        cfg_valid = 1;
        for (int i = 0; i < 2; i++) begin
            cfg_turn = 2'($urandom);
            #1;
            n_vec++;
            if (cfg_ready !== 1'b0) begin
                n_err++;
                $display("FAIL full_ready: cfg_ready=%b, expected 0", cfg_ready);
            end
            tick();
            n_vec++;
            if (count !== 4'd8) begin
                n_err++;
                $display("FAIL full_count: count=%0d, expected 8", count);
            end
        end
        cfg_valid = 0;
        run_check("full", MSB'($urandom), 0, 0, 1);
    endtask

    task automatic test_flags;
        clear_tbl();
        for (int i = 0; i < 4; i++) load(2'($urandom));
        run_check("flags_both", MSB'($urandom), 2, 2, 0);
        run_check("flags_done", MSB'($urandom), 0, 3, 0);
        run_check("flags_fail_first", MSB'($urandom), 1, 2, 0);
    endtask

    task automatic test_go_empty;
        clear_tbl();
        go = 1;
        target = MSB'($urandom);
        tick();
        go = 0;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (busy !== 1'b0 || startTime !== exp_start || count !== 4'd0) begin
                n_err++;
                $display("FAIL go_empty: busy=%b start=%0d count=%0d, expected busy=0 start=%0d count=0",
                         busy, startTime, count, exp_start);
            end
            tick();
        end
        load(2'b10);
        load(2'b01);
        go = 1;
        cfg_valid = 1;
        cfg_turn = 2'b11;
        target = 14'd777;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL go_write_ready: cfg_ready=%b, expected 0", cfg_ready);
        end
        tick();
        go = 0;
        cfg_valid = 0;
        exp_start = 14'd777;
        n_vec++;
        if (busy !== 1'b1 || count !== 4'd2 || {turnLarge, turnSmall} !== 2'b10 || startTime !== exp_start) begin
            n_err++;
            $display("FAIL go_write: busy=%b count=%0d turns=%b start=%0d, expected busy=1 count=2 turns=10 start=777",
                     busy, count, {turnLarge, turnSmall}, startTime);
        end
        for (int i = 0; i < 10 && busy; i++) tick();
    endtask

    task automatic test_reset_midrun;
        int rv_seen;
        clear_tbl();
        for (int i = 0; i < 5; i++) load(2'($urandom));
        go = 1;
        target = MSB'($urandom);
        tick();
        go = 0;
        tick();
        #2;
        reset = 1;
        #1;
        n_vec++;
        if (turnSmall !== 0 || turnLarge !== 0 || busy !== 0 || result_valid !== 0 || result !== RES_NONE || count !== 0 || startTime !== 0) begin
            n_err++;
            $display("FAIL reset_midrun: ts=%b tl=%b busy=%b rv=%b result=%b count=%0d start=%0d, expected all zero",
                     turnSmall, turnLarge, busy, result_valid, result, count, startTime);
        end
        @(negedge clock);
        reset = 0;
        tbl.delete();
        exp_start = 0;
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (result_valid !== 1'b0 || busy !== 1'b0) rv_seen++;
        end
        n_vec++;
        if (rv_seen != 0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_after: bad cycles=%0d count=%0d, expected 0 and 0", rv_seen, count);
        end
    endtask

    task automatic test_hourglass;
        bit saw_done, saw_rv;
        logic [1:0] res_at_rv;
        clear_tbl();
        load(2'b01);
        load(2'b00);
        use_model = 1;
        saw_done = 0;
        saw_rv = 0;
        res_at_rv = RES_NONE;
        go = 1;
        target = 14'd4;
        tick();
        go = 0;
        for (int i = 0; i < 10 && !saw_rv; i++) begin
            if (hg_done === 1'b1) saw_done = 1;
            if (result_valid === 1'b1) begin
                saw_rv = 1;
                res_at_rv = result;
            end
            tick();
        end
        use_model = 0;
        exp_start = 14'd4;
        n_vec++;
        if (!saw_done || !saw_rv || res_at_rv !== RES_DONE) begin
            n_err++;
            $display("FAIL hourglass: done_seen=%0d rv_seen=%0d result=%b, expected 1 1 %b", saw_done, saw_rv, res_at_rv, RES_DONE);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 25; it++) begin
            int n, k;
            if ($urandom_range(0, 3) == 0) clear_tbl();
            k = $urandom_range(0, 3);
            if (tbl.size() == 0 && k == 0) k = 1;
            for (int i = 0; i < k; i++) load(2'($urandom));
            n = tbl.size();
            n_vec++;
            if (count !== 4'(n)) begin
                n_err++;
                $display("FAIL random_count it %0d: count=%0d, expected %0d", it, count, n);
            end
            run_check("random", MSB'($urandom), $urandom_range(0, n + 1), $urandom_range(0, n + 1), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_flags();
        test_go_empty();
        test_reset_midrun();
        test_hourglass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
